// File: rtl/fc_dense_layer.sv
// Fully-connected layer: per output neuron, dot product of the flattened vector with a
// weight row plus bias, rounded and saturated to Q4.16 and written back to result memory.
module fc_dense_layer #(
    parameter int LEN     = 2048,
    parameter int NUM_OUT = 4,
    parameter int WAW     = 14,
    parameter int ACC_W   = 52,
    parameter int RELU    = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           crd,
    output logic [11:0]    caddr_rd,
    input  logic [19:0]    cdata_rd,
    output logic [2:0]     csel,
    output logic           cwr,
    output logic [11:0]    caddr_wr,
    output logic [19:0]    cdata_wr,
    output logic [WAW-1:0] waddr,
    input  logic [19:0]    wdata
);

    localparam int KW = $clog2(LEN + 1);
    localparam int OW = $clog2(NUM_OUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_BIAS,
        S_FINAL,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [KW-1:0]              r_k;
    logic [OW-1:0]              r_o;
    logic [WAW-1:0]             r_wPtr;
    logic [ACC_W-1:0]           r_acc;
    logic [ACC_W-1:0]           r_res;
    logic                       r_macValid;

    logic signed [39:0]         w_prod;
    logic [ACC_W-1:0]           w_prodExt;
    logic [ACC_W-1:0]           w_biasExt;
    logic [ACC_W-17:0]          w_hi;
    logic [ACC_W-16:0]          w_rnd;
    logic [ACC_W-35:0]          w_upper;
    logic [19:0]                w_outVal;

    assign w_prod    = $signed(cdata_rd) * $signed(wdata);
    assign w_prodExt = {{(ACC_W-40){w_prod[39]}}, w_prod};
    assign w_biasExt = {{(ACC_W-36){wdata[19]}}, wdata, 16'b0};

    // Weight rows are stored back to back, so the FETCH weight address is one running pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_k        <= '0;
            r_o        <= '0;
            r_wPtr     <= '0;
            r_acc      <= '0;
            r_res      <= '0;
            r_macValid <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_macValid <= (r_state == S_FETCH);
            if (r_macValid)
                r_acc <= r_acc + w_prodExt;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_k    <= '0;
                        r_o    <= '0;
                        r_wPtr <= '0;
                        r_acc  <= '0;
                    end
                end
                S_FETCH: begin
                    r_k    <= r_k + 1'b1;
                    r_wPtr <= r_wPtr + 1'b1;
                end
                S_FINAL: r_res <= r_acc + w_biasExt;
                S_WRITE: begin
                    r_acc <= '0;
                    r_k   <= '0;
                    r_o   <= r_o + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Round half-up on bit 15, then saturate the integer part to the 20-bit range.
    always_comb begin
        w_hi    = r_res[ACC_W-1:16];
        w_rnd   = {w_hi[ACC_W-17], w_hi} + {{(ACC_W-16){1'b0}}, r_res[15]};
        w_upper = w_rnd[ACC_W-16:19];
        if (w_upper == '0 || w_upper == '1)
            w_outVal = w_rnd[19:0];
        else if (w_rnd[ACC_W-16])
            w_outVal = 20'h80000;
        else
            w_outVal = 20'h7FFFF;
        if (RELU != 0 && r_res[ACC_W-1])
            w_outVal = 20'h00000;
    end

    always_comb begin
        w_next   = r_state;
        busy     = 1'b0;
        done     = 1'b0;
        crd      = 1'b0;
        cwr      = 1'b0;
        csel     = 3'b000;
        caddr_rd = '0;
        caddr_wr = '0;
        cdata_wr = '0;
        waddr    = '0;
        case (r_state)
            S_IDLE: begin
                if (start)
                    w_next = S_FETCH;
            end
            S_FETCH: begin
                busy     = 1'b1;
                crd      = 1'b1;
                csel     = 3'b101;
                caddr_rd = 12'(r_k);
                waddr    = r_wPtr;
                if (r_k == KW'(LEN - 1))
                    w_next = S_BIAS;
            end
            S_BIAS: begin
                busy   = 1'b1;
                waddr  = WAW'(NUM_OUT * LEN) + WAW'(r_o);
                w_next = S_FINAL;
            end
            S_FINAL: begin
                busy   = 1'b1;
                w_next = S_WRITE;
            end
            S_WRITE: begin
                busy     = 1'b1;
                cwr      = 1'b1;
                csel     = 3'b110;
                caddr_wr = 12'(r_o);
                cdata_wr = w_outVal;
                w_next   = (r_o == OW'(NUM_OUT - 1)) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fc_dense_layer.sv
// Self-checking bench for fc_dense_layer: four instances (default size, small, and two
// single-entry ones with and without ReLU) checked against an arithmetic golden model.
module tb_fc_dense_layer;

    logic       clk = 1'b0;
    logic [3:0] rstV = 4'hF;
    logic [3:0] startV = 4'h0;

    always #5 clk = ~clk;

    // Instance A: default size
    logic        busyA, doneA, crdA, cwrA;
    logic [11:0] caddrRdA, caddrWrA;
    logic [19:0] cdataRdA, cdataWrA, wdataA;
    logic [2:0]  cselA;
    logic [13:0] waddrA;
    // Instance B: LEN=4, NUM_OUT=2
    logic        busyB, doneB, crdB, cwrB;
    logic [11:0] caddrRdB, caddrWrB;
    logic [19:0] cdataRdB, cdataWrB, wdataB;
    logic [2:0]  cselB;
    logic [3:0]  waddrB;
    // Instances C (RELU=0) and D (RELU=1): LEN=1, NUM_OUT=2, sharing one memory image
    logic        busyC, doneC, crdC, cwrC, busyD, doneD, crdD, cwrD;
    logic [11:0] caddrRdC, caddrWrC, caddrRdD, caddrWrD;
    logic [19:0] cdataRdC, cdataWrC, wdataC, cdataRdD, cdataWrD, wdataD;
    logic [2:0]  cselC, cselD;
    logic [1:0]  waddrC, waddrD;

    logic [19:0] xA [0:2047];
    logic [19:0] wA [0:16383];
    logic [19:0] xB [0:3];
    logic [19:0] wB [0:15];
    logic [19:0] xC [0:1];
    logic [19:0] wC [0:3];

    fc_dense_layer #(.LEN(2048), .NUM_OUT(4), .WAW(14), .ACC_W(52), .RELU(0)) dutA (
        .clk(clk), .reset(rstV[0]), .start(startV[0]), .busy(busyA), .done(doneA),
        .crd(crdA), .caddr_rd(caddrRdA), .cdata_rd(cdataRdA), .csel(cselA), .cwr(cwrA),
        .caddr_wr(caddrWrA), .cdata_wr(cdataWrA), .waddr(waddrA), .wdata(wdataA));
    fc_dense_layer #(.LEN(4), .NUM_OUT(2), .WAW(4), .ACC_W(52), .RELU(0)) dutB (
        .clk(clk), .reset(rstV[1]), .start(startV[1]), .busy(busyB), .done(doneB),
        .crd(crdB), .caddr_rd(caddrRdB), .cdata_rd(cdataRdB), .csel(cselB), .cwr(cwrB),
        .caddr_wr(caddrWrB), .cdata_wr(cdataWrB), .waddr(waddrB), .wdata(wdataB));
    fc_dense_layer #(.LEN(1), .NUM_OUT(2), .WAW(2), .ACC_W(52), .RELU(0)) dutC (
        .clk(clk), .reset(rstV[2]), .start(startV[2]), .busy(busyC), .done(doneC),
        .crd(crdC), .caddr_rd(caddrRdC), .cdata_rd(cdataRdC), .csel(cselC), .cwr(cwrC),
        .caddr_wr(caddrWrC), .cdata_wr(cdataWrC), .waddr(waddrC), .wdata(wdataC));
    fc_dense_layer #(.LEN(1), .NUM_OUT(2), .WAW(2), .ACC_W(52), .RELU(1)) dutD (
        .clk(clk), .reset(rstV[3]), .start(startV[3]), .busy(busyD), .done(doneD),
        .crd(crdD), .caddr_rd(caddrRdD), .cdata_rd(cdataRdD), .csel(cselD), .cwr(cwrD),
        .caddr_wr(caddrWrD), .cdata_wr(cdataWrD), .waddr(waddrD), .wdata(wdataD));

    // Synchronous memories: data appears the cycle after the address
    always @(posedge clk) begin
        cdataRdA <= xA[caddrRdA[10:0]];
        wdataA   <= wA[waddrA];
        cdataRdB <= xB[caddrRdB[1:0]];
        wdataB   <= wB[waddrB];
        cdataRdC <= xC[caddrRdC[0]];
        wdataC   <= wC[waddrC];
        cdataRdD <= xC[caddrRdD[0]];
        wdataD   <= wC[waddrD];
    end

    int          probeSel = 0;
    logic        pBusy, pDone, pCrd, pCwr;
    logic [2:0]  pCsel;
    logic [11:0] pCaddrRd, pCaddrWr;
    logic [19:0] pCdataWr;
    logic [15:0] pWaddr;

    always_comb begin
        case (probeSel)
            0: begin
                pBusy = busyA; pDone = doneA; pCrd = crdA; pCwr = cwrA; pCsel = cselA;
                pCaddrRd = caddrRdA; pCaddrWr = caddrWrA; pCdataWr = cdataWrA;
                pWaddr = {2'b0, waddrA};
            end
            1: begin
                pBusy = busyB; pDone = doneB; pCrd = crdB; pCwr = cwrB; pCsel = cselB;
                pCaddrRd = caddrRdB; pCaddrWr = caddrWrB; pCdataWr = cdataWrB;
                pWaddr = {12'b0, waddrB};
            end
            2: begin
                pBusy = busyC; pDone = doneC; pCrd = crdC; pCwr = cwrC; pCsel = cselC;
                pCaddrRd = caddrRdC; pCaddrWr = caddrWrC; pCdataWr = cdataWrC;
                pWaddr = {14'b0, waddrC};
            end
            default: begin
                pBusy = busyD; pDone = doneD; pCrd = crdD; pCwr = cwrD; pCsel = cselD;
                pCaddrRd = caddrRdD; pCaddrWr = caddrWrD; pCdataWr = cdataWrD;
                pWaddr = {14'b0, waddrD};
            end
        endcase
    end

    int          vectors = 0;
    int          miscompares = 0;
    logic [19:0] lastData [0:7];

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [19:0] xVal(input int sel, input int k);
        if (sel == 0) return xA[k];
        if (sel == 1) return xB[k];
        return xC[k];
    endfunction

    function automatic logic [19:0] wVal(input int sel, input int a);
        if (sel == 0) return wA[a];
        if (sel == 1) return wB[a];
        return wC[a];
    endfunction

    function automatic longint sx(input logic [19:0] v);
        return longint'($signed(v));
    endfunction

    // Exact dot product in wide integer arithmetic, then Q4.16 rounding/saturation.
    function automatic logic [19:0] golden(input int sel, input int o, input int len,
                                           input int nOut, input int relu);
        longint acc = 0;
        longint r;
        longint q;
        for (int k = 0; k < len; k++)
            acc += sx(xVal(sel, k)) * sx(wVal(sel, o * len + k));
        r = acc + sx(wVal(sel, nOut * len + o)) * 65536;
        if (relu != 0 && r < 0) return 20'h00000;
        q = (r >>> 16) + longint'(r[15]);
        if (q > 524287) return 20'h7FFFF;
        if (q < -524288) return 20'h80000;
        return q[19:0];
    endfunction

    // Runs one start on instance sel; optional extra start pulses while busy, optional
    // reset at cycle abortAt (cycle 0 is the cycle in which start is high).
    task automatic applyStimulus(input int sel, input int len, input int nOut, input int relu,
                                 input int extraStarts, input int abortAt);
        int          cyc = 0;
        int          budget = nOut * (len + 3) + 12;
        int          nWr = 0;
        int          doneCnt = 0;
        int          doneCyc = -1;
        int          expK = 0;
        int          readErr = 0;
        int          ctrlErr = 0;
        int          quietErr = 0;
        int          maxW = 0;
        bit          prevCrd = 0;
        bit          stop = 0;
        bit          aborted = 0;
        logic [11:0] wrAddr [0:7];
        logic [19:0] wrData [0:7];
        logic [2:0]  expCsel;

        probeSel = sel;
        @(negedge clk);
        startV[sel] = 1'b1;
        while (cyc < budget && !stop) begin
            @(negedge clk);
            cyc++;
            startV[sel] = (extraStarts != 0 && (cyc == 2 || cyc == 4 || cyc == len + 5));
            expCsel = pCrd ? 3'b101 : (pCwr ? 3'b110 : 3'b000);
            if (pCsel != expCsel || (pCrd && pCwr)) ctrlErr++;
            if (doneCyc < 0 && pBusy != (cyc <= nOut * (len + 3))) ctrlErr++;
            if (int'(pWaddr) > maxW) maxW = int'(pWaddr);
            if (pCrd) begin
                if (int'(pCaddrRd) != expK % len || int'(pWaddr) != expK) readErr++;
                expK++;
            end else if (prevCrd) begin
                if (int'(pWaddr) != nOut * len + expK / len - 1) readErr++;
            end
            prevCrd = pCrd;
            if (pCwr) begin
                if (nWr < 8) begin
                    wrAddr[nWr] = pCaddrWr;
                    wrData[nWr] = pCdataWr;
                end
                nWr++;
            end
            if (pDone) begin
                doneCnt++;
                if (doneCyc < 0) doneCyc = cyc;
            end
            if (abortAt == cyc) begin
                rstV[sel] = 1'b1;
                @(negedge clk);
                checkOutput("abort_idle", 64'({pBusy, pCrd, pCwr}), 64'(0));
                rstV[sel] = 1'b0;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    if (pCwr || pBusy || pCrd || pDone) quietErr++;
                end
                checkOutput("abort_quiet", 64'(quietErr), 64'(0));
                checkOutput("abort_writes", 64'(nWr), 64'(abortAt / (len + 3)));
                aborted = 1;
                stop = 1;
            end
            if (doneCyc >= 0 && cyc >= doneCyc + 3) stop = 1;
        end
        startV[sel] = 1'b0;

        if (!aborted) begin
            checkOutput("done_cycle", 64'(doneCyc), 64'(nOut * (len + 3) + 1));
            checkOutput("done_count", 64'(doneCnt), 64'(1));
            checkOutput("write_count", 64'(nWr), 64'(nOut));
            checkOutput("read_order", 64'(readErr), 64'(0));
            checkOutput("reads_total", 64'(expK), 64'(nOut * len));
            checkOutput("ctrl_err", 64'(ctrlErr), 64'(0));
            checkOutput("waddr_last", 64'(maxW), 64'(nOut * len + nOut - 1));
            for (int i = 0; i < nOut && i < nWr && i < 8; i++) begin
                checkOutput($sformatf("wr%0d_addr", i), 64'(wrAddr[i]), 64'(i));
                checkOutput($sformatf("wr%0d_data", i), 64'(wrData[i]),
                            64'(golden(sel, i, len, nOut, relu)));
                lastData[i] = wrData[i];
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) wB[i] = 20'h0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            probeSel = s;
            #1;
            checkOutput($sformatf("reset_outputs%0d", s),
                        64'({pBusy, pDone, pCrd, pCwr, pCsel, pCaddrRd, pCaddrWr, pCdataWr, pWaddr}),
                        64'(0));
        end
        @(negedge clk);
        rstV = 4'h0;

        $display("[TB] constant vector, LEN=4 NUM_OUT=2");
        for (int i = 0; i < 4; i++) xB[i] = 20'h10000;
        for (int i = 0; i < 8; i++) wB[i] = 20'h08000;
        wB[8] = 20'h0; wB[9] = 20'h0;
        applyStimulus(1, 4, 2, 0, 0, 0);
        checkOutput("t1_const0", 64'(lastData[0]), 64'(20'h20000));
        checkOutput("t1_const1", 64'(lastData[1]), 64'(20'h20000));

        $display("[TB] rounding at bit 15");
        xC[0] = 20'h00001; xC[1] = 20'h0;
        wC[0] = 20'h08000; wC[1] = 20'h07FFF; wC[2] = 20'h0; wC[3] = 20'h0;
        applyStimulus(2, 1, 2, 0, 0, 0);
        checkOutput("t2_round_up", 64'(lastData[0]), 64'(20'h00001));
        checkOutput("t2_round_down", 64'(lastData[1]), 64'(20'h00000));

        $display("[TB] saturation and ReLU");
        xC[0] = 20'h7FFFF;
        wC[0] = 20'h7FFFF; wC[1] = 20'h80000;
        applyStimulus(2, 1, 2, 0, 0, 0);
        checkOutput("t3_sat_pos", 64'(lastData[0]), 64'(20'h7FFFF));
        checkOutput("t3_sat_neg", 64'(lastData[1]), 64'(20'h80000));
        applyStimulus(3, 1, 2, 1, 0, 0);
        checkOutput("t3_relu_pos", 64'(lastData[0]), 64'(20'h7FFFF));
        checkOutput("t3_relu_neg", 64'(lastData[1]), 64'(20'h00000));

        $display("[TB] random small layer with start pulses while busy");
        for (int i = 0; i < 4; i++) xB[i] = 20'($urandom);
        for (int i = 0; i < 10; i++) wB[i] = 20'($urandom_range(0, 65535)) - 20'd32768;
        applyStimulus(1, 4, 2, 0, 1, 0);

        $display("[TB] reset during neuron 1 fetch, then clean restart");
        applyStimulus(1, 4, 2, 0, 0, 9);
        applyStimulus(1, 4, 2, 0, 0, 0);

        $display("[TB] random default-size layer");
        for (int i = 0; i < 2048; i++) xA[i] = 20'($urandom_range(0, 131071));
        for (int i = 0; i < 8196; i++) wA[i] = 20'($urandom_range(0, 4095)) - 20'd2048;
        applyStimulus(0, 2048, 4, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
